// File: rtl/mmio_responder.sv
// mmio_responder: 16-word MMIO window with a TX FIFO stream, an RX holding
// register, a status register and a scratch register. Read data is
// registered for one-cycle load latency.
module mmio_responder #(
  parameter int unsigned     WIDTH      = 16,
  parameter logic [WIDTH-1:0] BASE_ADDR = 16'hFF00,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter int unsigned     FIFO_AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] data_to_mem_store,
  input  logic             write_to_memory,
  input  logic             reading_for_load,
  output logic [WIDTH-1:0] io_data_out,
  output logic             io_hit,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready
);

  localparam int unsigned CW = FIFO_AW + 1;

  localparam logic [3:0] OFF_TXDATA  = 4'd0;
  localparam logic [3:0] OFF_RXDATA  = 4'd1;
  localparam logic [3:0] OFF_STATUS  = 4'd2;
  localparam logic [3:0] OFF_SCRATCH = 4'd3;

  logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_tx_overflow;
  logic               r_rx_full;
  logic [WIDTH-1:0]   r_rx_data;
  logic [WIDTH-1:0]   r_scratch;
  logic               r_io_hit;
  logic [WIDTH-1:0]   r_io_data;

  logic               w_sel;
  logic [3:0]         w_off;
  logic               w_wr;
  logic               w_rd;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_ovf_set;
  logic               w_ovf_clr;
  logic               w_rx_accept;
  logic               w_rx_clear;
  logic [WIDTH-1:0]   w_status;
  logic [WIDTH-1:0]   w_rd_data;

  // Address decode and bus strobes
  assign w_sel = (mem_address[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
  assign w_off = mem_address[3:0];
  assign w_wr  = w_sel && write_to_memory;
  assign w_rd  = w_sel && reading_for_load;

  // FIFO control; a push into a full FIFO only succeeds if a pop frees a slot
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == CW'(0));
  assign w_push    = w_wr && (w_off == OFF_TXDATA);
  assign w_pop     = out_valid && out_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_ovf_clr = w_wr && (w_off == OFF_STATUS) && data_to_mem_store[3];

  // RX handshake; reading RXDATA frees the holding register
  assign in_ready    = !r_rx_full && !reset;
  assign w_rx_accept = in_valid && in_ready;
  assign w_rx_clear  = w_rd && (w_off == OFF_RXDATA);

  // Stream outputs come straight from FIFO state
  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rd_ptr];

  assign io_hit      = r_io_hit;
  assign io_data_out = r_io_data;

  // Status word and read-data mux
  always_comb begin
    w_status                = '0;
    w_status[FIFO_AW+4:4]   = r_count;
    w_status[3]             = r_tx_overflow;
    w_status[2]             = r_rx_full;
    w_status[1]             = w_empty;
    w_status[0]             = w_full;
    w_rd_data               = '0;
    case (w_off)
      OFF_RXDATA:  w_rd_data = r_rx_data;
      OFF_STATUS:  w_rd_data = w_status;
      OFF_SCRATCH: w_rd_data = r_scratch;
      default:     w_rd_data = '0;
    endcase
  end

  // TX FIFO storage, pointers and count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= data_to_mem_store;
        r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_tx_overflow <= 1'b0;
    else if (w_ovf_set) r_tx_overflow <= 1'b1;
    else if (w_ovf_clr) r_tx_overflow <= 1'b0;
  end

  // RX holding register; an accept never coincides with a full register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_full <= 1'b0;
      r_rx_data <= '0;
    end else if (w_rx_accept) begin
      r_rx_full <= 1'b1;
      r_rx_data <= in_data;
    end else if (w_rx_clear) begin
      r_rx_full <= 1'b0;
    end
  end

  // Scratch register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_scratch <= '0;
    else if (w_wr && (w_off == OFF_SCRATCH))  r_scratch <= data_to_mem_store;
  end

  // Registered read response; captures pre-write register values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_io_hit  <= 1'b0;
      r_io_data <= '0;
    end else begin
      r_io_hit  <= w_rd;
      r_io_data <= w_rd ? w_rd_data : '0;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: read responses and TX stream words
// are queued at issue time and checked by independent monitors.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_address = '0;
  logic [15:0] data_to_mem_store = '0;
  logic        write_to_memory = 1'b0;
  logic        reading_for_load = 1'b0;
  logic [15:0] io_data_out;
  logic        io_hit;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rd_q[$];
  logic [15:0] tx_q[$];

  mmio_responder dut (
    .clk               (clk),
    .reset             (reset),
    .mem_address       (mem_address),
    .data_to_mem_store (data_to_mem_store),
    .write_to_memory   (write_to_memory),
    .reading_for_load  (reading_for_load),
    .io_data_out       (io_data_out),
    .io_hit            (io_hit),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-response monitor
  always @(negedge clk) begin
    if (io_hit) begin
      if (rd_q.size() == 0) check("unexpected_io_hit", 16'd1, 16'd0);
      else check("read_data", io_data_out, rd_q.pop_front());
    end
  end

  // TX stream monitor; a word transfers when valid and ready meet
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (tx_q.size() == 0) check("unexpected_tx_word", out_data, 16'hxxxx);
      else check("tx_word", out_data, tx_q.pop_front());
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // One bus cycle starting just after a rising edge; returns just after the next one
  task automatic bus(input logic wr, input logic rd, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic exp_q, input logic [15:0] exp_rd);
    mem_address       = addr;
    data_to_mem_store = wdata;
    write_to_memory   = wr;
    reading_for_load  = rd;
    if (rd && exp_q) rd_q.push_back(exp_rd);
    @(posedge clk); #1;
    write_to_memory   = 1'b0;
    reading_for_load  = 1'b0;
  endtask

  task automatic wr_tx(input logic [15:0] d, input logic accepted);
    if (accepted) tx_q.push_back(d);
    bus(1'b1, 1'b0, 16'hFF00, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp);
    bus(1'b0, 1'b1, addr, '0, 1'b1, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_io_hit", 16'(io_hit), 16'd0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 16'(in_ready), 16'd1);
    rd(16'hFF02, 16'h0002);

    // Fill FIFO, overflow, drain in order
    wr_tx(16'h1111, 1'b1);
    wr_tx(16'h2222, 1'b1);
    wr_tx(16'h3333, 1'b1);
    wr_tx(16'h4444, 1'b1);
    rd(16'hFF02, 16'h0041);
    wr_tx(16'h5555, 1'b0);
    rd(16'hFF02, 16'h0049);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("drained_out_valid", 16'(out_valid), 16'd0);
    tick();
    rd(16'hFF02, 16'h000A);
    bus(1'b1, 1'b0, 16'hFF02, 16'h0008, 1'b0, '0);
    rd(16'hFF02, 16'h0002);

    // Push into a full FIFO with a simultaneous pop
    wr_tx(16'h6666, 1'b1);
    wr_tx(16'h7777, 1'b1);
    wr_tx(16'h8888, 1'b1);
    wr_tx(16'h9999, 1'b1);
    out_ready = 1'b1;
    wr_tx(16'hAAAA, 1'b1);
    out_ready = 1'b0;
    rd(16'hFF02, 16'h0041);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    rd(16'hFF02, 16'h0002);

    // RX holding register and back-pressure
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    @(negedge clk);
    check("rx_ready_before", 16'(in_ready), 16'd1);
    tick();
    in_data = 16'hCAFE;
    @(negedge clk);
    check("rx_ready_after_accept", 16'(in_ready), 16'd0);
    tick(); tick();
    check("rx_ready_held", 16'(in_ready), 16'd0);
    rd(16'hFF01, 16'hBEEF);
    @(negedge clk);
    check("rx_ready_after_read", 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("rx_ready_cafe_held", 16'(in_ready), 16'd0);
    tick();
    rd(16'hFF02, 16'h0006);
    rd(16'hFF01, 16'hCAFE);

    // Scratch: same-cycle write and read returns the old value
    bus(1'b1, 1'b1, 16'hFF03, 16'h5A5A, 1'b1, 16'h0000);
    rd(16'hFF03, 16'h5A5A);

    // Outside the window
    bus(1'b0, 1'b1, 16'h0100, '0, 1'b0, '0);
    @(negedge clk);
    check("oow_io_hit", 16'(io_hit), 16'd0);
    check("oow_io_data", io_data_out, 16'h0000);
    tick();
    rd(16'hFF04, 16'h0000);

    // Reset mid-operation cancels the pending response and drops FIFO contents
    wr_tx(16'h1234, 1'b0);
    bus(1'b0, 1'b1, 16'hFF03, '0, 1'b0, '0);
    check("pending_io_hit", 16'(io_hit), 16'd1);
    check("pending_io_data", io_data_out, 16'h5A5A);
    check("pending_out_valid", 16'(out_valid), 16'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_io_hit", 16'(io_hit), 16'd0);
    check("rst_mid_out_valid", 16'(out_valid), 16'd0);
    check("rst_mid_out_data", out_data, 16'h0000);
    check("rst_mid_in_ready", 16'(in_ready), 16'd0);
    tick();
    reset = 1'b0;
    tick();
    rd(16'hFF02, 16'h0002);
    rd(16'hFF03, 16'h0000);
    tick(); tick();

    check("rd_queue_drained", 16'(rd_q.size()), 16'd0);
    check("tx_queue_drained", 16'(tx_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
